fetch_queue: RTL

Instruction prefetch queue between the program counter/instruction memory side and the IFID pipeline register. It issues sequential fetch requests over a req/ack handshake to a variable-latency instruction memory and buffers up to DEPTH returned words with their PC+4. It presents the head entry to IFID under a valid/ready handshake (ready = IFIDWrite). A branch/jump redirect (PCSrc|jump) flushes the queue and restarts fetch at the target, discarding any in-flight stale response.

---
 rtl/fetch_queue.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to imem and buffers DEPTH words for IFID.
// Latency: a word is visible the cycle after its mem_ack (same cycle via bypass when FETCH_QUEUE_BYPASS_EN is defined).
// Backpressure: inst_ready low holds the head; issue stops while the queue is full; redirect flushes.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_rdata_i,
  output logic                     inst_valid_o,
  output logic [31:0]              inst_o,
  output logic [31:0]              inst_pc_plus4_o,
  input  logic                     inst_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     word_q [DEPTH];
  logic [31:0]     pc4_q  [DEPTH];

  logic            head_vld;
  logic            ack_ok;
  logic            pop;
  logic            push;
  logic            byp_vld;
  logic            byp_take;
  logic            issue;

  // Handshake qualifiers; a redirect voids any push or pop in its cycle.
  always_comb begin
    head_vld = (count_q != '0);
    ack_ok   = (state_q == BUSY) && mem_ack_i && !redirect_i;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_vld  = ack_ok && !head_vld;
    byp_take = byp_vld && inst_ready_i;
`else
    byp_vld  = 1'b0;
    byp_take = 1'b0;
`endif
    pop      = head_vld && inst_ready_i && !redirect_i;
    push     = ack_ok && !byp_take;
  end

  // Occupancy and pointer next-state; redirect empties the queue.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Request FSM: redirect has priority; a request in flight at redirect becomes stale and is drained.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end else if (count_q < DEPTH_C) begin
          issue = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          if (redirect_i) begin
            state_d    = IDLE;
            fetch_pc_d = redirect_pc_i;
          end else if (count_d < DEPTH_C) begin
            issue = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_i) begin
          state_d    = DISCARD;
          fetch_pc_d = redirect_pc_i;
        end
      end
      DISCARD: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (issue) begin
      state_d    = BUSY;
      req_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents are only observed through count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      word_q[wr_ptr_q] <= mem_rdata_i;
      pc4_q[wr_ptr_q]  <= req_addr_q + 32'd4;
    end
  end

  // Head presentation, with the optional same-cycle pass-through when empty.
  always_comb begin
    mem_req_o       = (state_q != IDLE);
    mem_addr_o      = req_addr_q;
    count_o         = count_q;
    inst_valid_o    = head_vld || byp_vld;
    inst_o          = 32'd0;
    inst_pc_plus4_o = 32'd0;
    if (head_vld) begin
      inst_o          = word_q[rd_ptr_q];
      inst_pc_plus4_o = pc4_q[rd_ptr_q];
    end else if (byp_vld) begin
      inst_o          = mem_rdata_i;
      inst_pc_plus4_o = req_addr_q + 32'd4;
    end
  end

endmodule
